// File: rtl/essr_access_arbiter_pkg.sv
// Shared types for the essr access arbiter: FSM states and operation encodings.
package essr_access_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_e;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/essr_access_arbiter_if.sv
// Requester/cell bundle around the arbiter; slave is the arbiter side.
interface essr_access_arbiter_if #(
    parameter int NREQ = 5
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] op;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            done;
    logic            err;
    logic            essr_x;
    logic            essr_z;
    logic            essr_g;

    modport slave (
        input  req, op, essr_g,
        output gnt, busy, done, err, essr_x, essr_z
    );

    modport master (
        output req, op, essr_g,
        input  gnt, busy, done, err, essr_x, essr_z
    );
endinterface

// File: rtl/essr_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above ptr, wrapping around.
module rr_pick #(
    parameter int NREQ = 5,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);
    logic found;
    int   c;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        c     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            c = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[c]) begin
                found = 1'b1;
                idx_o = IW'(c);
            end
        end
        gnt_o = found ? (NREQ'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/essr_access_arbiter.sv
// Shares one essr set/reset cell among NREQ requesters: grant, pulse x or z, await g.
module essr_access_arbiter
    import essr_access_arbiter_pkg::*;
#(
    parameter int NREQ      = 5,
    parameter int PULSE_LEN = 2,
    parameter int TIMEOUT   = 8,
    parameter int CW        = 4
) (
    input  logic clk_i,
    input  logic r_i,
    essr_access_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            op_q, op_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            x_q, x_d;
    logic            z_q, z_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        gnt_d   = gnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        x_d     = 1'b0;
        z_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d = S_DRIVE;
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    op_d    = bus.op[pick_idx];
                    cnt_d   = '0;
                    x_d     = bus.op[pick_idx];
                    z_d     = ~bus.op[pick_idx];
                end
            end
            S_DRIVE: begin
                // Drive registers are loaded one edge ahead so the pulse spans DRIVE exactly.
                if (cnt_q == CW'(PULSE_LEN - 1)) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    x_d   = op_q;
                    z_d   = ~op_q;
                end
            end
            S_CHECK: begin
                if (bus.essr_g == op_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ptr_d   = idx_q;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (r_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= IW'(NREQ - 1);
            idx_q   <= '0;
            op_q    <= OP_CLR;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            x_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            x_q     <= x_d;
            z_q     <= z_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.essr_x = x_q;
    assign bus.essr_z = z_q;
endmodule
